// File: rtl/ram_arbiter.sv
// Round-robin arbiter that lets a CPU and a program loader share one synchronous RAM port.
// Each granted access runs IDLE -> GRANT -> ACCESS -> RESP, with all outputs registered.
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              owner
);

    // state  | meaning
    // IDLE   | no transaction, arbitrate pending requests
    // GRANT  | latched address/data on the RAM, write strobe for writes
    // ACCESS | RAM read data arriving, captured into rdata on exit
    // RESP   | one-cycle ack to the owner
    typedef enum logic [1:0] {IDLE, GRANT, ACCESS, RESP} state_t;

    state_t state;
    logic   last_served;
    logic   lat_we;
    logic   pick_ldr;

    // The loader wins when it is alone, or on a tie when the CPU was served last.
    always_comb begin
        pick_ldr = ldr_req && (!cpu_req || !last_served);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cpu_ack     <= 1'b0;
            ldr_ack     <= 1'b0;
            ram_we      <= 1'b0;
            busy        <= 1'b0;
            owner       <= 1'b0;
            rdata       <= '0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            last_served <= 1'b1;
            lat_we      <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            ram_we  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || ldr_req) begin
                        state       <= GRANT;
                        busy        <= 1'b1;
                        owner       <= pick_ldr;
                        last_served <= pick_ldr;
                        ram_addr    <= pick_ldr ? ldr_addr : cpu_addr;
                        ram_wdata   <= pick_ldr ? ldr_wdata : cpu_wdata;
                        ram_we      <= pick_ldr ? ldr_we : cpu_we;
                        lat_we      <= pick_ldr ? ldr_we : cpu_we;
                    end
                end
                GRANT: begin
                    state <= ACCESS;
                end
                ACCESS: begin
                    state <= RESP;
                    if (!lat_we) begin
                        rdata <= ram_rdata;
                    end
                    cpu_ack <= !owner;
                    ldr_ack <= owner;
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM and hand-computed expectations.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_we, ldr_req, ldr_we;
    logic [7:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic       cpu_ack, ldr_ack, ram_we, busy, owner;
    logic [7:0] rdata, ram_addr, ram_wdata, ram_rdata;

    logic [7:0] mem [256];
    logic       pre_we = 1'b0;
    logic [7:0] pre_addr = '0;
    logic [7:0] pre_data = '0;
    int         wr_cnt = 0;
    logic [7:0] wr_addr = '0;
    logic [7:0] wr_data = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack),
        .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
    );

    // Read-first synchronous RAM; the preload port lets the bench seed contents.
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr_cnt        <= wr_cnt + 1;
            wr_addr       <= ram_addr;
            wr_data       <= ram_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // Issue one request from IDLE (called just after a rising edge) and check latency and ack.
    task automatic xfer(input string tag, input bit is_ldr, input bit we,
                        input logic [7:0] a, input logic [7:0] wd, input logic [7:0] exp_rd);
        int lat;
        bit got;
        if (is_ldr) begin
            ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            if (is_ldr ? ldr_ack : cpu_ack) got = 1'b1;
            else lat++;
        end
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_other_ack"}, is_ldr ? cpu_ack : ldr_ack, 0);
        chk({tag, "_rdata"}, rdata, exp_rd);
        @(posedge clk);
        #1;
        if (is_ldr) ldr_req = 1'b0;
        else cpu_req = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_drop"}, is_ldr ? ldr_ack : cpu_ack, 0);
        chk({tag, "_idle"}, busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] ca, la;
        logic [8:0]  bv, cv, lv;
        int w0;

        rst = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
        preload(8'h12, 8'hA5);
        preload(8'h10, 8'h5A);
        preload(8'h05, 8'h11);
        preload(8'h20, 8'hEE);

        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_acks", {cpu_ack, ldr_ack}, 0);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // CPU read with loader idle
        xfer("cpu_rd12", 1'b0, 1'b0, 8'h12, 8'h00, 8'hA5);
        chk("cpu_rd12_no_write", wr_cnt, 0);

        // Loader write then CPU read-back; rdata holds across the write
        w0 = wr_cnt;
        xfer("ldr_wr40", 1'b1, 1'b1, 8'h40, 8'h3C, 8'hA5);
        chk("ldr_wr40_count", wr_cnt, w0 + 1);
        chk("ldr_wr40_addr", wr_addr, 8'h40);
        chk("ldr_wr40_data", wr_data, 8'h3C);
        chk("ldr_wr40_mem", mem[8'h40], 8'h3C);
        chk("ldr_idle_owner", owner, 1);
        xfer("cpu_rd40", 1'b0, 1'b0, 8'h40, 8'h00, 8'h3C);

        // CPU address changes after the grant edge must not reach the RAM
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        @(posedge clk);
        #1 cpu_addr = 8'h20;
        @(negedge clk);
        chk("hold_addr_grant", ram_addr, 8'h10);
        @(negedge clk);
        chk("hold_addr_access", ram_addr, 8'h10);
        @(negedge clk);
        chk("hold_addr_resp", ram_addr, 8'h10);
        chk("hold_ack", cpu_ack, 1);
        chk("hold_rdata", rdata, 8'h5A);
        @(posedge clk);
        #1 cpu_req = 1'b0;

        // Loader request arriving during the CPU's ACCESS waits for the next IDLE
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12;
        bv = '0; cv = '0; lv = '0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bv[i] = busy;
            cv[i] = cpu_ack;
            lv[i] = ldr_ack;
            @(posedge clk);
            #1;
            if (i == 1) begin
                ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h10;
            end
            if (i == 3) cpu_req = 1'b0;
            if (i == 7) ldr_req = 1'b0;
        end
        chk("late_busy", bv, 9'h0EE);
        chk("late_cpu_ack", cv, 9'h008);
        chk("late_ldr_ack", lv, 9'h080);
        chk("late_rdata", rdata, 8'h5A);

        // Reset during the GRANT of a loader write: no write, no ack, immediate reset values
        w0 = wr_cnt;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h05; ldr_wdata = 8'h77;
        @(negedge clk);
        @(negedge clk);
        chk("abort_grant_we", ram_we, 1);
        chk("abort_grant_addr", ram_addr, 8'h05);
        #1 rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ram_we", ram_we, 0);
        chk("abort_owner", owner, 0);
        chk("abort_rdata", rdata, 0);
        chk("abort_ram_bus", {ram_addr, ram_wdata}, 0);
        chk("abort_ldr_ack", ldr_ack, 0);
        ldr_req = 1'b0; ldr_we = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("abort_mem", mem[8'h05], 8'h11);
        chk("abort_wr_cnt", wr_cnt, w0);
        @(posedge clk);
        #1;
        xfer("post_rst_rd", 1'b0, 1'b0, 8'h12, 8'h00, 8'hA5);

        // Both requesting from reset: CPU, loader, CPU, loader at four cycles each
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h10;
        ca = '0; la = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ca[i] = cpu_ack;
            la[i] = ldr_ack;
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        chk("rr_cpu_acks", ca, 16'h0808);
        chk("rr_ldr_acks", la, 16'h8080);
        chk("rr_overlap", ca & la, 16'h0000);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL declare parameter ADDR_W, default 8, RAM address width.
REQ-002 The block SHALL declare parameter DATA_W, default 8, RAM data width.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports cpu_req/cpu_we, input, 1 each, CPU access request / write qualifier.
REQ-006 The block SHALL have ports cpu_addr (ADDR_W) and cpu_wdata (DATA_W), input, CPU address / write data.
REQ-007 The block SHALL have port cpu_ack, output, 1, one-cycle completion pulse to CPU.
REQ-008 The block SHALL have ports ldr_req/ldr_we, input, 1 each, program-loader request / write qualifier.
REQ-009 The block SHALL have ports ldr_addr (ADDR_W) and ldr_wdata (DATA_W), input, loader address / write data.
REQ-010 The block SHALL have port ldr_ack, output, 1, one-cycle completion pulse to loader.
REQ-011 The block SHALL have port rdata, output, DATA_W, registered read data shared by both requesters.
REQ-012 The block SHALL have ports ram_addr (ADDR_W), ram_wdata (DATA_W) and ram_we (1), output, to the synchronous RAM.
REQ-013 The block SHALL have port ram_rdata, input, DATA_W; RAM read data valid one cycle after ram_addr is sampled.
REQ-014 The block SHALL have ports busy (1) and owner (1, 0=CPU, 1=loader), output, arbiter status.

Function
REQ-015 The FSM SHALL have states IDLE, GRANT, ACCESS, RESP; every non-IDLE state lasts exactly one cycle.
REQ-016 In IDLE with any req high, the edge SHALL latch winner's we/addr/wdata into internal registers, set owner, go GRANT.
REQ-017 Arbitration SHALL be round-robin: one req -> that requester; both -> requester not equal to last_served.
REQ-018 last_served SHALL update to the winner at the IDLE->GRANT edge.
REQ-019 ram_addr/ram_wdata SHALL drive the latched registers in GRANT, ACCESS and RESP; requester inputs changing after the grant edge SHALL have no effect.
REQ-020 ram_we SHALL be high only in GRANT and only for a latched write; exactly one RAM write per granted write.
REQ-021 GRANT->ACCESS->RESP unconditionally; the ACCESS->RESP edge SHALL load rdata from ram_rdata for reads; rdata SHALL hold its value for writes.
REQ-022 In RESP the owner's ack SHALL be high for exactly one cycle; the other ack SHALL stay low; RESP->IDLE unconditionally.
REQ-023 Latency: req sampled high at edge N (IDLE) -> ack high in cycle after edge N+2; read data valid in rdata in that same cycle and held until the next read completes.
REQ-024 Requesters SHALL hold req and operands stable until ack, and drop req on the edge that samples ack; req high in IDLE after RESP is a new request.
REQ-025 busy SHALL be high in GRANT, ACCESS, RESP and low in IDLE; owner SHALL hold its value in IDLE.
REQ-026 A req arriving while busy SHALL wait (no loss, no preemption) and be arbitrated in the next IDLE cycle.
REQ-027 Addresses SHALL pass unmodified; no wrap, increment or width conversion.

Reset
REQ-028 rst low SHALL immediately force state IDLE, cpu_ack=0, ldr_ack=0, ram_we=0, busy=0, owner=0, rdata=0, ram_addr=0, ram_wdata=0, last_served=1 (CPU wins first tie).
REQ-029 Reset mid-transaction SHALL abort it with no ack; a write aborted before its GRANT edge SHALL not reach RAM.
REQ-030 After rst rises, the first edge SHALL evaluate IDLE arbitration normally.

Verification
REQ-031 CPU read addr 0x12 (RAM[0x12]=0xA5), loader idle -> ram_we=0, cpu_ack one cycle 3 edges after req, rdata=0xA5, ldr_ack=0.
REQ-032 Loader write 0x3C->0x40 then CPU read 0x40 -> one ram_we pulse with ram_addr=0x40, ram_wdata=0x3C; CPU rdata=0x3C.
REQ-033 Both req high from reset, held continuously -> grants CPU, loader, CPU, loader; acks alternate, never simultaneous, 4 cycles per grant.
REQ-034 Loader req raised during CPU ACCESS -> CPU acked first; loader granted in following IDLE; busy low for exactly one cycle between.
REQ-035 rst driven low during GRANT of loader write 0x77->0x05 -> outputs reset values asynchronously, no ldr_ack, RAM[0x05] unchanged if reset precedes GRANT edge.
REQ-036 CPU changes cpu_addr 0x10->0x20 one cycle after grant -> ram_addr stays 0x10 through RESP.
